// File: rtl/nios_setup_nios2e_cpu_ocimem_arbiter.sv
// nios_setup_nios2e_cpu_ocimem_arbiter: round-robin OCI RAM access between the JTAG command slot and the Avalon debug slave.
module nios_setup_nios2e_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wrdata,
  input  logic [DATA_W-1:0] ram_rddata
);
  localparam logic [2:0] IDLE = 3'd0, J_WR = 3'd1, J_RD = 3'd2, J_DAT = 3'd3,
                         A_WR = 3'd4, A_RD = 3'd5, A_DAT = 3'd6;
  logic [2:0] state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic slot_v, slot_wr, last_av;
  logic [DATA_W-1:0] slot_data;
  logic j_req, j_wr, multi, accept, drop, av_req, grant_j, done_j, j_st, a_st;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign av_readdata = ram_rddata;
  assign monitor_ready = !slot_v;
  // _a takes priority over the other two commands; _no_action_a over _b
  always_comb begin
    j_req = take_action_ocimem_a ? jdo[35] : (take_no_action_ocimem_a | take_action_ocimem_b);
    j_wr = !take_action_ocimem_a && !take_no_action_ocimem_a && take_action_ocimem_b;
    multi = (take_action_ocimem_a && (take_no_action_ocimem_a || take_action_ocimem_b)) ||
            (take_no_action_ocimem_a && take_action_ocimem_b);
    accept = j_req && !slot_v;
    drop = (j_req && slot_v) || multi;
    av_req = av_read || av_write;
    grant_j = slot_v && (!av_req || last_av);
    done_j = state == J_WR || state == J_DAT;
    j_st = state == J_WR || state == J_RD || state == J_DAT;
    a_st = state == A_WR || state == A_RD || state == A_DAT;
    state_n = state == IDLE ? (grant_j ? (slot_wr ? J_WR : J_RD) :
                               av_req ? (av_write ? A_WR : A_RD) : IDLE) :
              state == J_RD ? J_DAT :
              state == A_RD ? A_DAT : IDLE;
    ram_wren = state == J_WR || state == A_WR;
    ram_addr = j_st ? ptr : a_st ? av_address : '0;
    ram_wrdata = state == J_WR ? slot_data : state == A_WR ? av_writedata : '0;
    av_waitrequest = av_req && !(state == A_WR || state == A_DAT);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      slot_v <= 1'b0;
      slot_wr <= 1'b0;
      slot_data <= '0;
      last_av <= 1'b1;
      MonDReg <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) last_av <= !grant_j;
      if (state == J_DAT) MonDReg <= ram_rddata;
      if (done_j) begin
        slot_v <= 1'b0;
        ptr <= ptr + 1'b1;
      end
      if (accept) begin
        slot_v <= 1'b1;
        slot_wr <= j_wr;
        slot_data <= jdo[34:3];
      end
      if (take_action_ocimem_a) ptr <= jdo[17 +: ADDR_W];
      // a lone _a clears the flag even if its own read was dropped; a colliding command still flags
      if (take_action_ocimem_a && !multi) jtag_overrun <= 1'b0;
      else if (drop) jtag_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nios_setup_nios2e_cpu_ocimem_arbiter.sv
// tb_nios_setup_nios2e_cpu_ocimem_arbiter: directed checks of JTAG/Avalon OCI RAM arbitration against a bench RAM.
module tb_nios_setup_nios2e_cpu_ocimem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic take_action_ocimem_a = 1'b0, take_no_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0;
  logic [31:0] MonDReg, av_readdata, ram_wrdata, ram_rddata, av_writedata = '0;
  logic monitor_ready, jtag_overrun, av_waitrequest, ram_wren;
  logic [7:0] av_address = '0, ram_addr;
  logic av_read = 1'b0, av_write = 1'b0;
  logic [31:0] mem [256];
  int n_chk = 0, n_pass = 0, n_wr = 0;
  always #5 clk = ~clk;
  nios_setup_nios2e_cpu_ocimem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata)
  );
  // single-port RAM, 1-clk read latency; each word starts as C0DE_00xx
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else begin
      if (ram_wren) begin
        mem[ram_addr] <= ram_wrdata;
        n_wr <= n_wr + 1;
      end
      ram_rddata <= mem[ram_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [37:0] ja(input logic rd, input logic [7:0] addr);
    return (38'(rd) << 35) | (38'(addr) << 17);
  endfunction
  function automatic logic [37:0] jb(input logic [31:0] data);
    return 38'(data) << 3;
  endfunction
  task automatic jcmd(input logic a, input logic na, input logic b, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    tick;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && !monitor_ready; i++) tick;
    chk(tag, 32'(monitor_ready), 32'd1);
  endtask
  initial begin
    logic [7:0] order [$];
    logic [7:0] exp_ord [8];
    logic av_done;
    int jn, an;
    exp_ord = '{8'h40, 8'h80, 8'h41, 8'h81, 8'h42, 8'h82, 8'h43, 8'h83};
    av_read = 1'b1;
    repeat (3) tick;
    chk("rst_waitreq", 32'(av_waitrequest), 32'd1);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_overrun", 32'(jtag_overrun), 32'd0);
    av_read = 1'b0;
    reset_n = 1'b1;
    tick;
    jcmd(1'b1, 1'b0, 1'b0, ja(1'b0, 8'h10));
    jcmd(1'b0, 1'b0, 1'b1, jb(32'hDEADBEEF));
    chk("wr_busy", 32'(monitor_ready), 32'd0);
    wait_ready("wr1_done");
    jcmd(1'b0, 1'b0, 1'b1, jb(32'h12345678));
    wait_ready("wr2_done");
    chk("ram_10", mem[8'h10], 32'hDEADBEEF);
    chk("ram_11", mem[8'h11], 32'h12345678);
    jcmd(1'b0, 1'b1, 1'b0, '0);
    wait_ready("rd_ptr_done");
    chk("ptr_after_wr", MonDReg, 32'hC0DE_0012);
    jcmd(1'b1, 1'b0, 1'b0, ja(1'b1, 8'h10));
    wait_ready("rd1_done");
    chk("rd_10", MonDReg, 32'hDEADBEEF);
    jcmd(1'b0, 1'b1, 1'b0, '0);
    wait_ready("rd2_done");
    chk("rd_11", MonDReg, 32'h12345678);
    jcmd(1'b0, 1'b1, 1'b0, '0);
    wait_ready("rd3_done");
    chk("ptr_after_rd", MonDReg, 32'hC0DE_0012);
    av_address = 8'h11;
    av_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("av_rd_wait%0d", c), 32'(av_waitrequest), c == 2 ? 32'd0 : 32'd1);
      if (c == 2) chk("av_rd_data", av_readdata, 32'h12345678);
      tick;
    end
    av_read = 1'b0;
    // Avalon was granted last; a streaming Avalon writer against a JTAG writer must alternate starting with JTAG
    jcmd(1'b1, 1'b0, 1'b0, ja(1'b0, 8'h40));
    jn = 0;
    an = 0;
    av_done = 1'b0;
    for (int k = 0; k < 60 && order.size() < 8; k++) begin
      if (av_done) begin
        an++;
        av_address = 8'h80 + 8'(an);
        av_writedata = 32'hA0 + 32'(an);
      end
      if (k == 1) begin
        av_write = 1'b1;
        av_address = 8'h80;
        av_writedata = 32'hA0;
      end
      take_action_ocimem_b = 1'b0;
      if (monitor_ready && jn < 4) begin
        jdo = jb(32'hB0 + 32'(jn));
        take_action_ocimem_b = 1'b1;
        jn++;
      end
      #1;
      if (ram_wren) order.push_back(ram_addr);
      av_done = av_write && !av_waitrequest;
      tick;
    end
    av_write = 1'b0;
    take_action_ocimem_b = 1'b0;
    chk("rr_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8 && i < order.size(); i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_ord[i]));
    chk("rr_jdata", mem[8'h43], 32'hB3);
    chk("rr_adata", mem[8'h83], 32'hA3);
    wait_ready("rr_idle");
    jcmd(1'b1, 1'b0, 1'b0, ja(1'b0, 8'hFF));
    jcmd(1'b0, 1'b0, 1'b1, jb(32'hA5));
    wait_ready("wrap_wr_done");
    chk("ram_ff", mem[8'hFF], 32'hA5);
    jcmd(1'b0, 1'b0, 1'b1, jb(32'h1));
    chk("ovr_before", 32'(jtag_overrun), 32'd0);
    jcmd(1'b0, 1'b0, 1'b1, jb(32'h2));
    chk("ovr_set", 32'(jtag_overrun), 32'd1);
    wait_ready("wrap_wr2_done");
    chk("ram_00_wrap", mem[8'h00], 32'h1);
    chk("ram_01_untouched", mem[8'h01], 32'hC0DE_0001);
    repeat (3) tick;
    chk("ovr_sticky", 32'(jtag_overrun), 32'd1);
    jcmd(1'b1, 1'b0, 1'b0, ja(1'b0, 8'h00));
    chk("ovr_clear", 32'(jtag_overrun), 32'd0);
    chk("wren_pulses", 32'(n_wr), 32'd12);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
